pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Arbitrates four hazard sources: instruction-fetch wait states, data-memory wait states, load-use hazards, and branch/jump mispredict flushes from the PC-calculation unit.
- Drives the PC-unit stall and the per-stage hold/kill controls of the pipeline registers.
- Tracks non-abortable in-flight fetches with a small FSM so that stale instructions are dropped after a redirect.

Parameters:
- WAIT_LIMIT, 255: maximum consecutive memory-wait cycles before mem_timeout is raised.
- CNT_W, 32: width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- br_flush  in  1  mispredict flush from PC unit; EX-stage branch resolved wrong
- imem_ready  in  1  fetch at current PC complete; held high while stall_if=1
- dmem_req  in  1  MEM-stage load/store active
- dmem_ready  in  1  data access complete this cycle
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of EX instruction
- id_rs1, id_rs2  in  5 each  source registers of ID instruction
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2
- stall_if  out  1  hold PC (drives PC unit stall)
- stall_id, stall_ex, stall_mem  out  1 each  hold IF/ID, ID/EX, EX/MEM registers
- kill_id  out  1  load NOP into IF/ID at next edge
- kill_ex  out  1  load NOP into ID/EX at next edge
- mem_timeout  out  1  sticky watchdog flag
- state_o  out  2  current FSM state, for debug

Behaviour:
- Reset: state=RUN, wait counter=0, mem_timeout=0. All stall_* and kill_* outputs are 0 while rstn=0.
- States: RUN=0, IWAIT=1, DISCARD=2, DWAIT=3. DWAIT saves the pre-freeze state in ret_state (RUN, IWAIT or DISCARD).
- Priority, evaluated every cycle:
  - freeze (dmem_req && !dmem_ready) > br_flush > load-use > fetch wait.
- Freeze:
  - stall_if, stall_id, stall_ex and stall_mem all 1; kill_* 0.
  - br_flush and load-use are ignored, because EX is frozen and re-presents them after the freeze.
  - From a non-DWAIT state: enter DWAIT and save ret_state.
  - In DWAIT with dmem_ready=1: outputs are those of ret_state evaluated this cycle; next state is ret_state.
- Flush (br_flush=1, not frozen):
  - stall_if=0, so the PC loads the redirect target; kill_id=1, kill_ex=1; stall_id/ex/mem=0.
  - If state=IWAIT and imem_ready=0 (stale fetch in flight): next state=DISCARD. Otherwise next state=RUN.
- Load-use:
  - Condition: ex_mem_read, ex_rd!=0, and (id_use_rs1 && id_rs1==ex_rd) or (id_use_rs2 && id_rs2==ex_rd).
  - Response: stall_if=1, stall_id=1, kill_ex=1; exactly a 1-cycle bubble; stays in the same state.
  - If fetch wait coincides, kill_id stays 0 because IF/ID is held.
- RUN/IWAIT fetch wait:
  - imem_ready=0: stall_if=1, kill_id=1 (bubble enters ID), downstream advances; next state=IWAIT.
  - imem_ready=1: next state=RUN.
- DISCARD:
  - stall_if=1; kill_id=1 every cycle.
  - On imem_ready=1 the stale response is dropped and next state=RUN; the target fetch starts next cycle.
- Watchdog:
  - Counter increments each cycle in IWAIT, DISCARD or DWAIT, and clears on any other state.
  - When the counter reaches WAIT_LIMIT, set mem_timeout; it clears only on reset. The counter saturates.
- Reset asserted mid-wait: all state is discarded immediately and the FSM returns to RUN.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds CNT_W-bit output ports perf_stall_cyc, perf_flush_cnt, perf_lu_cnt.
  - perf_stall_cyc counts cycles with stall_if=1.
  - perf_flush_cnt counts accepted br_flush events.
  - perf_lu_cnt counts load-use bubbles.
  - All three reset to 0 and saturate at all-ones.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg: state enum (RUN, IWAIT, DISCARD, DWAIT) and a REG_ZERO=5'd0 constant.
- One sub-module, hazard_wdog: watchdog counter plus sticky flag, parameterised by WAIT_LIMIT.
- Load-use compare stays inline.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → one cycle of stall_if=1, stall_id=1, kill_ex=1, then all 0. Repeat with ex_rd=0 → no stall.
- Fetch wait: imem_ready=0 for 3 cycles → state=IWAIT, stall_if=1 and kill_id=1 for 3 cycles; RUN on the cycle after imem_ready=1.
- Redirect during fetch wait: in IWAIT assert br_flush=1 with imem_ready=0 → stall_if=0, kill_id=kill_ex=1. Next state DISCARD, kill_id=1 until imem_ready=1, then RUN.
- Data freeze: dmem_req=1, dmem_ready=0 for 4 cycles with br_flush=1 → all four stalls=1, kill_*=0, flush ignored. On dmem_ready=1 the flush is taken and the FSM returns to ret_state.
- Watchdog: WAIT_LIMIT=8, hold imem_ready=0 → mem_timeout rises after 8 wait cycles and stays set after imem_ready=1; cleared only by rstn.
- Reset mid-DWAIT: drop rstn → state_o=0 and all outputs 0 asynchronously. With HAZARD_PERF_EN, counters read 0 after reset and increment by 1 per event.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    IWAIT   = 2'd1,
    DISCARD = 2'd2,
    DWAIT   = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Any state other than RUN means the pipeline is waiting on memory.
  function automatic logic is_wait_state(input state_e s);
    return s != RUN;
  endfunction

endpackage

// File: rtl/hazard_wdog.sv
// rtl/hazard_wdog.sv - consecutive memory-wait counter with sticky timeout flag
module hazard_wdog #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic wait_i,
  output logic timeout_o
);

  localparam int            CW    = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Counter saturates at the limit; the flag stays set until reset.
  always_comb begin
    cnt_d = '0;
    if (wait_i) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CW'(1);
    end
    timeout_d = timeout_q | (wait_i && (cnt_d == LIMIT));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush scheduler for the 5-stage pipeline
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             br_flush,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             kill_id,
  output logic             kill_ex,
  output logic             mem_timeout,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_lu_cnt,
`endif
  output logic [1:0]       state_o
);

  if (WAIT_LIMIT < 1 || CNT_W < 1) begin : g_param_chk
    $error("pipe_hazard_ctrl: WAIT_LIMIT and CNT_W must be >= 1");
  end

  state_e state_q, state_d;
  state_e ret_q, ret_d;
  state_e eff_state;

  logic freeze, load_use, rs1_hit, rs2_hit;
  logic stall_if_c, stall_id_c, stall_ex_c, stall_mem_c, kill_id_c, kill_ex_c;

  assign freeze   = dmem_req & ~dmem_ready;
  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

  // When a freeze ends, the cycle behaves as the saved pre-freeze state.
  assign eff_state = (state_q == DWAIT) ? ret_q : state_q;

  always_comb begin
    stall_if_c  = 1'b0;
    stall_id_c  = 1'b0;
    stall_ex_c  = 1'b0;
    stall_mem_c = 1'b0;
    kill_id_c   = 1'b0;
    kill_ex_c   = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;

    if (freeze) begin
      stall_if_c  = 1'b1;
      stall_id_c  = 1'b1;
      stall_ex_c  = 1'b1;
      stall_mem_c = 1'b1;
      state_d     = DWAIT;
      if (state_q != DWAIT) begin
        ret_d = state_q;
      end
    end else if (br_flush) begin
      kill_id_c = 1'b1;
      kill_ex_c = 1'b1;
      state_d   = (eff_state == IWAIT && !imem_ready) ? DISCARD : RUN;
    end else if (load_use) begin
      // IF/ID is held, so no kill_id even when a fetch is still pending.
      stall_if_c = 1'b1;
      stall_id_c = 1'b1;
      kill_ex_c  = 1'b1;
      state_d    = eff_state;
    end else begin
      case (eff_state)
        DISCARD: begin
          stall_if_c = 1'b1;
          kill_id_c  = 1'b1;
          state_d    = imem_ready ? RUN : DISCARD;
        end
        default: begin
          if (!imem_ready) begin
            stall_if_c = 1'b1;
            kill_id_c  = 1'b1;
            state_d    = IWAIT;
          end else begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      ret_q   <= RUN;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  assign stall_if  = rstn & stall_if_c;
  assign stall_id  = rstn & stall_id_c;
  assign stall_ex  = rstn & stall_ex_c;
  assign stall_mem = rstn & stall_mem_c;
  assign kill_id   = rstn & kill_id_c;
  assign kill_ex   = rstn & kill_ex_c;
  assign state_o   = state_q;

  hazard_wdog #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wdog (
    .clk       (clk),
    .rstn      (rstn),
    .wait_i    (is_wait_state(state_q)),
    .timeout_o (mem_timeout)
  );

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cyc_q, flush_cnt_q, lu_cnt_q;
  logic             flush_ev, lu_ev;

  assign flush_ev = br_flush & ~freeze;
  assign lu_ev    = load_use & ~freeze & ~br_flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      if (stall_if && !(&stall_cyc_q)) stall_cyc_q <= stall_cyc_q + CNT_W'(1);
      if (flush_ev && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (lu_ev && !(&lu_cnt_q))       lu_cnt_q    <= lu_cnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_lu_cnt    = lu_cnt_q;
`endif

endmodule
